// File: rtl/wb_arbiter_pkg.sv
// Shared register-file bus types and defaults for the write-back arbiter.
// The FIFO entry packs destination address and result data into one 37-bit word.
package wb_arbiter_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] reg_data_t;

  localparam reg_data_t ZeroWord     = '0;
  localparam reg_addr_t NOPRegAddr   = '0;
  localparam logic      WriteEnable  = 1'b1;
  localparam logic      WriteDisable = 1'b0;

  localparam int WbFifoDepth = 2;
  localparam int StarveMax   = 8;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_entry_t;

  // Register 0 is hardwired, so any write to it is a no-op.
  function automatic logic writes_reg(input logic we, input reg_addr_t addr);
    return we && (addr != NOPRegAddr);
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back bus: MEM result, divider handshake, regfile write port, ID hazard
// check and starvation request. The slave side is the arbiter itself.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic      mem_we;
  reg_addr_t mem_waddr;
  reg_data_t mem_wdata;
  logic      stall;
  logic      flush;

  logic      div_valid;
  reg_addr_t div_waddr;
  reg_data_t div_wdata;
  logic      div_ready;

  logic      wb_we;
  reg_addr_t wb_waddr;
  reg_data_t wb_wdata;

  reg_addr_t chk_addr1;
  reg_addr_t chk_addr2;
  logic      chk_hit1;
  logic      chk_hit2;

  logic      starve_req;

  modport master (
    output mem_we, mem_waddr, mem_wdata, stall, flush,
    output div_valid, div_waddr, div_wdata,
    input  div_ready,
    input  wb_we, wb_waddr, wb_wdata,
    output chk_addr1, chk_addr2,
    input  chk_hit1, chk_hit2,
    input  starve_req
  );

  modport slave (
    input  mem_we, mem_waddr, mem_wdata, stall, flush,
    input  div_valid, div_waddr, div_wdata,
    output div_ready,
    output wb_we, wb_waddr, wb_wdata,
    input  chk_addr1, chk_addr2,
    output chk_hit1, chk_hit2,
    output starve_req
  );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// In-order divider result FIFO. Every entry address is exported together with a
// valid bit so the ID hazard check can compare against all pending writes.
module wb_arbiter_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WbFifoDepth
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  wb_entry_t                   push_entry,
  input  logic                        pop,
  output wb_entry_t                   head,
  output logic                        full,
  output logic                        empty,
  output logic      [DEPTH-1:0]       entry_valid,
  output reg_addr_t [DEPTH-1:0]       entry_addr
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t       mem_reg [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_reg[rd_ptr_reg];

  // Storage carries no reset; the valid vector alone decides what is live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [AW-1:0] offset;
      assign offset          = AW'(gi) - rd_ptr_reg;
      assign entry_valid[gi] = ({1'b0, offset} < count_reg);
      assign entry_addr[gi]  = mem_reg[gi].addr;
    end
  endgenerate

endmodule

// File: rtl/wb_arbiter.sv
// Write-back stage: owns the regfile write port, gives MEM results priority and
// drains queued divider results into the slots the pipeline leaves free.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = WbFifoDepth,
  parameter int STARVE_MAX = StarveMax
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic                   live;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  wb_entry_t              head;
  wb_entry_t              push_entry;
  logic      [DEPTH-1:0]  entry_valid;
  reg_addr_t [DEPTH-1:0]  entry_addr;
  logic      [DEPTH-1:0]  match1;
  logic      [DEPTH-1:0]  match2;

  logic                   wb_we_reg;
  reg_addr_t              wb_waddr_reg;
  reg_data_t              wb_wdata_reg;
  logic      [CW-1:0]     starve_cnt_reg;
  logic      [CW-1:0]     starve_cnt_next;
  logic                   starve_req_reg;

  assign live = writes_reg(bus.mem_we, bus.mem_waddr) && !bus.stall && !bus.flush;
  assign pop  = !live && !empty;

  // Ready is forced low during reset so nothing transfers into a clearing FIFO.
  assign bus.div_ready = rst && !full;
  assign push          = bus.div_valid && bus.div_ready &&
                         (bus.div_waddr != NOPRegAddr);
  assign push_entry    = '{addr: bus.div_waddr, data: bus.div_wdata};

  wb_arbiter_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_we_reg    <= WriteDisable;
      wb_waddr_reg <= NOPRegAddr;
      wb_wdata_reg <= ZeroWord;
    end else if (live) begin
      wb_we_reg    <= WriteEnable;
      wb_waddr_reg <= bus.mem_waddr;
      wb_wdata_reg <= bus.mem_wdata;
    end else if (!empty) begin
      wb_we_reg    <= WriteEnable;
      wb_waddr_reg <= head.addr;
      wb_wdata_reg <= head.data;
    end else begin
      wb_we_reg    <= WriteDisable;
    end
  end

  assign bus.wb_we    = wb_we_reg;
  assign bus.wb_waddr = wb_waddr_reg;
  assign bus.wb_wdata = wb_wdata_reg;

  // Counts edges where queued results wait behind the pipeline; saturates.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (empty || pop) begin
      starve_cnt_next = '0;
    end else if (starve_cnt_reg < CW'(STARVE_MAX)) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_reg <= '0;
      starve_req_reg <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      starve_req_reg <= (starve_cnt_next >= CW'(STARVE_MAX));
    end
  end

  assign bus.starve_req = starve_req_reg;

  // A result still on the divider handshake counts as pending too.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
      assign match1[gi] = entry_valid[gi] && (entry_addr[gi] == bus.chk_addr1);
      assign match2[gi] = entry_valid[gi] && (entry_addr[gi] == bus.chk_addr2);
    end
  endgenerate

  assign bus.chk_hit1 = (bus.chk_addr1 != NOPRegAddr) &&
                        ((|match1) || (bus.div_valid && (bus.div_waddr == bus.chk_addr1)));
  assign bus.chk_hit2 = (bus.chk_addr2 != NOPRegAddr) &&
                        ((|match2) || (bus.div_valid && (bus.div_waddr == bus.chk_addr2)));

endmodule

// File: tb/tb_wb_arbiter.sv
// Vector-driven bench for wb_arbiter: pre-edge checks of ready/hazard/starve,
// post-edge checks of the regfile write port through a scoreboard queue.
module tb_wb_arbiter;

  logic clk;
  logic rst;

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        stall;
    logic        flush;
    logic        div_valid;
    logic [4:0]  div_waddr;
    logic [31:0] div_wdata;
    logic [4:0]  chk1;
    logic [4:0]  chk2;
    logic        e_ready;
    logic        e_hit1;
    logic        e_hit2;
    logic        e_starve;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_exp_t;

  int      tests = 0;
  int      fails = 0;
  vec_t    tbl[$];
  wb_exp_t sb_q[$];

  function automatic vec_t mk(int mwe, int ma, int md, int st, int fl,
                              int dv, int da, int dd, int c1, int c2,
                              int er, int h1, int h2, int sr,
                              int we, int wa, int wd);
    vec_t v;
    v.mem_we    = mwe[0];
    v.mem_waddr = ma[4:0];
    v.mem_wdata = md;
    v.stall     = st[0];
    v.flush     = fl[0];
    v.div_valid = dv[0];
    v.div_waddr = da[4:0];
    v.div_wdata = dd;
    v.chk1      = c1[4:0];
    v.chk2      = c2[4:0];
    v.e_ready   = er[0];
    v.e_hit1    = h1[0];
    v.e_hit2    = h2[0];
    v.e_starve  = sr[0];
    v.e_we      = we[0];
    v.e_waddr   = wa[4:0];
    v.e_wdata   = wd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.mem_we    = 1'b0;
    bus.mem_waddr = '0;
    bus.mem_wdata = '0;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.div_valid = 1'b0;
    bus.div_waddr = '0;
    bus.div_wdata = '0;
    bus.chk_addr1 = '0;
    bus.chk_addr2 = '0;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic apply(input vec_t v, input string tag);
    wb_exp_t e;
    bus.mem_we    = v.mem_we;
    bus.mem_waddr = v.mem_waddr;
    bus.mem_wdata = v.mem_wdata;
    bus.stall     = v.stall;
    bus.flush     = v.flush;
    bus.div_valid = v.div_valid;
    bus.div_waddr = v.div_waddr;
    bus.div_wdata = v.div_wdata;
    bus.chk_addr1 = v.chk1;
    bus.chk_addr2 = v.chk2;
    #1;
    check({tag, ".div_ready"},  32'(bus.div_ready),  32'(v.e_ready));
    check({tag, ".chk_hit1"},   32'(bus.chk_hit1),   32'(v.e_hit1));
    check({tag, ".chk_hit2"},   32'(bus.chk_hit2),   32'(v.e_hit2));
    check({tag, ".starve_req"}, 32'(bus.starve_req), 32'(v.e_starve));
    sb_q.push_back('{we: v.e_we, waddr: v.e_waddr, wdata: v.e_wdata});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".wb_we"},    32'(bus.wb_we),    32'(e.we));
    check({tag, ".wb_waddr"}, 32'(bus.wb_waddr), 32'(e.waddr));
    check({tag, ".wb_wdata"}, bus.wb_wdata,      e.wdata);
    $display("[TB] %-8s mem_we=%0b ma=%0d div_v=%0b da=%0d rdy=%0b hit=%0b%0b starve=%0b -> wb_we=%0b wa=%0d wd=%0h",
             tag, v.mem_we, v.mem_waddr, v.div_valid, v.div_waddr, v.e_ready,
             v.e_hit1, v.e_hit2, v.e_starve, bus.wb_we, bus.wb_waddr, bus.wb_wdata);
    @(negedge clk);
  endtask

  initial begin
    // mem_we,ma,md,stall,flush, dv,da,dd, chk1,chk2, ready,hit1,hit2,starve, we,wa,wd
    // Pipeline only, including r0, stall and flush bubbles.
    tbl.push_back(mk(1, 5, 'h1234, 0, 0,  0, 0, 0,        0, 0,   1, 0, 0, 0,  1, 5, 'h1234));
    tbl.push_back(mk(1, 0, 'hFFFF, 0, 0,  0, 0, 0,        0, 0,   1, 0, 0, 0,  0, 5, 'h1234));
    tbl.push_back(mk(1, 6, 'h66,   1, 0,  0, 0, 0,        0, 0,   1, 0, 0, 0,  0, 5, 'h1234));
    tbl.push_back(mk(1, 9, 'h99,   0, 1,  0, 0, 0,        0, 0,   1, 0, 0, 0,  0, 5, 'h1234));
    // Idle drain of r7 then r8, no bypass.
    tbl.push_back(mk(0, 0, 0,      0, 0,  1, 7, 'hAAAA,   8, 7,   1, 0, 1, 0,  0, 5, 'h1234));
    tbl.push_back(mk(0, 0, 0,      0, 0,  1, 8, 'hBBBB,   8, 7,   1, 1, 1, 0,  1, 7, 'hAAAA));
    tbl.push_back(mk(0, 0, 0,      0, 0,  0, 0, 0,        8, 7,   1, 1, 0, 0,  1, 8, 'hBBBB));
    tbl.push_back(mk(0, 0, 0,      0, 0,  0, 0, 0,        8, 7,   1, 0, 0, 0,  0, 8, 'hBBBB));
    // Divider result to r0 is accepted and discarded.
    tbl.push_back(mk(0, 0, 0,      0, 0,  1, 0, 'h1111,   0, 0,   1, 0, 0, 0,  0, 8, 'hBBBB));
    tbl.push_back(mk(0, 0, 0,      0, 0,  0, 0, 0,        0, 0,   1, 0, 0, 0,  0, 8, 'hBBBB));
    // Flushed MEM slot lets the pending entry drain.
    tbl.push_back(mk(1, 3, 'h33,   0, 0,  1, 10, 'hA0,    3, 10,  1, 0, 1, 0,  1, 3, 'h33));
    tbl.push_back(mk(1, 3, 'h3333, 0, 1,  0, 0, 0,        10, 3,  1, 1, 0, 0,  1, 10, 'hA0));
    tbl.push_back(mk(0, 0, 0,      0, 0,  0, 0, 0,        10, 0,  1, 0, 0, 0,  0, 10, 'hA0));
    // Full FIFO backpressure with a held third result.
    tbl.push_back(mk(1, 1, 'h101,  0, 0,  1, 11, 'hB1,    11, 0,  1, 1, 0, 0,  1, 1, 'h101));
    tbl.push_back(mk(1, 2, 'h102,  0, 0,  1, 12, 'hB2,    11, 12, 1, 1, 1, 0,  1, 2, 'h102));
    tbl.push_back(mk(1, 3, 'h103,  0, 0,  1, 13, 'hB3,    13, 12, 0, 1, 1, 0,  1, 3, 'h103));
    tbl.push_back(mk(1, 4, 'h104,  1, 0,  1, 13, 'hB3,    13, 11, 0, 1, 1, 0,  1, 11, 'hB1));
    tbl.push_back(mk(1, 4, 'h104,  0, 0,  1, 13, 'hB3,    11, 12, 1, 0, 1, 0,  1, 4, 'h104));
    tbl.push_back(mk(0, 0, 0,      0, 0,  0, 0, 0,        12, 13, 0, 1, 1, 0,  1, 12, 'hB2));
    tbl.push_back(mk(0, 0, 0,      0, 0,  0, 0, 0,        12, 13, 1, 0, 1, 0,  1, 13, 'hB3));
    tbl.push_back(mk(0, 0, 0,      0, 0,  0, 0, 0,        0, 13,  1, 0, 0, 0,  0, 13, 'hB3));

    rst = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset.wb_we",      32'(bus.wb_we),      32'd0);
    check("reset.wb_waddr",   32'(bus.wb_waddr),   32'd0);
    check("reset.wb_wdata",   bus.wb_wdata,        32'd0);
    check("reset.div_ready",  32'(bus.div_ready),  32'd0);
    check("reset.starve_req", 32'(bus.starve_req), 32'd0);
    rst = 1'b1;
    #1;
    check("release.div_ready", 32'(bus.div_ready), 32'd1);
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Starvation: one queued entry behind continuous live writes, then a stall.
    apply(mk(1, 21, 0, 0, 0,  1, 20, 'hC0,  20, 0,  1, 1, 0, 0,  1, 21, 0), "stv0");
    for (int k = 1; k <= 10; k++) begin
      apply(mk(1, 21, k, 0, 0,  0, 0, 0,  20, 0,  1, 1, 0, (k - 1 >= 8) ? 1 : 0,  1, 21, k),
            $sformatf("stv%0d", k));
    end
    apply(mk(1, 21, 11, 1, 0,  0, 0, 0,  20, 0,  1, 1, 0, 1,  1, 20, 'hC0), "stv11");
    apply(mk(0, 0, 0, 0, 0,    0, 0, 0,  20, 0,  1, 0, 0, 0,  0, 20, 'hC0), "stv12");

    // Reset mid-operation with two queued entries.
    apply(mk(1, 26, 'hE1, 0, 0,  1, 25, 'hD1,  25, 0,   1, 1, 0, 0,  1, 26, 'hE1), "rmid0");
    apply(mk(1, 28, 'hE2, 0, 0,  1, 27, 'hD2,  25, 27,  1, 1, 1, 0,  1, 28, 'hE2), "rmid1");
    drive_idle();
    rst = 1'b0;
    #1;
    check("rmid.wb_we",      32'(bus.wb_we),      32'd0);
    check("rmid.wb_waddr",   32'(bus.wb_waddr),   32'd0);
    check("rmid.div_ready",  32'(bus.div_ready),  32'd0);
    check("rmid.starve_req", 32'(bus.starve_req), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    apply(mk(0, 0, 0, 0, 0,  0, 0, 0,  25, 27,  1, 0, 0, 0,  0, 0, 0), "rmid2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back stage and owner of the single register-file write port (we/waddr/wdata).
- Merges two writers:
  - the in-order pipeline result from MEM;
  - out-of-order results from a multi-cycle unit (divider) via valid/ready.
- Divider results queue in a small in-order FIFO and drain into slots the pipeline leaves free.
- Provides a pending-write hazard check for ID and a starvation request to the stall controller.

Parameters:
- DEPTH, 2, divider result FIFO entries (power of two, >=2)
- STARVE_MAX, 8, cycles a non-empty FIFO may go without a pop before starve_req asserts

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- mem_we  in  1  MEM-stage write enable
- mem_waddr  in  5  MEM-stage destination register (RegAddrBus)
- mem_wdata  in  32  MEM-stage result (RegBus)
- stall  in  1  MEM delivers a bubble this cycle
- flush  in  1  discard this cycle's MEM result
- div_valid  in  1  divider result valid
- div_waddr  in  5  divider destination
- div_wdata  in  32  divider result
- div_ready  out  1  FIFO can accept
- wb_we  out  1  to regfile we
- wb_waddr  out  5  to regfile waddr
- wb_wdata  out  32  to regfile wdata
- chk_addr1  in  5  ID source-1 address
- chk_addr2  in  5  ID source-2 address
- chk_hit1  out  1  chk_addr1 has an outstanding divider write
- chk_hit2  out  1  chk_addr2 has an outstanding divider write
- starve_req  out  1  request a pipeline bubble to drain the FIFO

Behaviour:
- Reset (rst low, asynchronous):
  - wb_we=0, wb_waddr=0, wb_wdata=0.
  - FIFO empty; starvation counter 0; starve_req=0.
  - div_ready=0 while rst is low.
- The pipeline slot is "live" when mem_we=1, stall=0, flush=0 and mem_waddr!=0.
- Each rising edge, in priority order:
  - Live slot: wb_* <= mem_*, wb_we=1.
  - Else, FIFO non-empty: pop the head; wb_* <= head, wb_we=1.
  - Else: wb_we <= 0; wb_waddr/wb_wdata hold their values.
- Writes to register 0 are dropped and never consume a slot. A divider result addressed to 0 is accepted and discarded (not pushed).
- Divider handshake:
  - div_ready = !full (combinational from registered state).
  - Transfer occurs on an edge with div_valid&&div_ready.
  - A push while full is impossible. A pop on the same edge does not make ready rise in the same cycle.
  - div_waddr/div_wdata must hold while div_valid=1 and div_ready=0.
- Latency:
  - Pipeline result appears on wb_* 1 edge after MEM presents it.
  - Divider result accepted at edge t is visible on wb_* after edge t+1 at the earliest. There is no bypass.
- Ordering: FIFO strictly in order. Simultaneous push and pop are legal when not full, and the count is unchanged.
- flush drops only the current MEM slot. Accepted FIFO entries are architectural and are never flushed.
- Hazard check (combinational):
  - chk_hitN=1 if chk_addrN!=0 and it matches either a valid FIFO entry or div_waddr while div_valid=1.
  - ID stalls on a hit, so the pipeline never overtakes a pending write to the same register.
- Starvation:
  - The counter increments on each edge where the FIFO is non-empty and no pop occurs.
  - The counter clears on a pop or when the FIFO is empty.
  - starve_req (registered) =1 while count>=STARVE_MAX.
  - The counter saturates at STARVE_MAX.
- Pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.

Decomposition:
- Shared define.v supplies RegAddrBus, RegBus, ZeroWord, NOPRegAddr, WriteEnable/WriteDisable. Add WbFifoDepth and StarveMax defaults there.
- One sub-module, wb_fifo:
  - parameterised synchronous FIFO (DEPTH x 37 bits, address+data);
  - push/pop/full/empty;
  - per-entry valid vector plus addresses exported for the hazard compare.

Test Plan:
- Reset mid-operation: FIFO holding 2 entries, assert rst low between edges -> wb_we=0, div_ready=0 immediately; after release the FIFO is empty, div_ready=1, chk_hit1=0 for prior addresses.
- Pipeline only: mem_we=1, waddr=5, wdata=0x1234 for 1 cycle -> next edge wb_we=1, wb_waddr=5, wb_wdata=0x1234; r0 write with stall=0 -> wb_we=0.
- Idle drain: div pushes (7,0xAAAA) then (8,0xBBBB) with no pipeline writes -> wb writes r7 then r8 on consecutive edges, first one edge after acceptance; chk_addr1=8 hits until its pop edge.
- Full/backpressure: DEPTH=2, continuous live pipeline writes, three div results offered -> two accepted, div_ready=0, third held with div_valid; after the first pop div_ready returns to 1 the following cycle and the third transfers.
- Starvation: FIFO non-empty, pipeline live every cycle -> starve_req=1 after 8 edges; one stall cycle -> FIFO pops, counter clears, starve_req=0 next edge.
- flush with a pending FIFO entry: flush=1 alongside mem_we=1 (r3) -> r3 not written, FIFO entry drains that edge.
